// File: rtl/four_12_12_st1_out_frame.sv
// Purpose: re-frames the stage-1 output stream into whole FRAME_LEN-element frames using two ping-pong banks; partial or fst-less data is dropped and counted.
// Latency: the edge that accepts a frame's last element marks its bank full, and element 0 is presented from the next cycle.
// Backpressure: in_rdy = !full[wr_bank]; it is a registered flag with no combinational path from out_rdy.
module four_12_12_st1_out_frame #(
    parameter int FRAME_LEN = 12,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fst,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fst,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wstate_t;

    logic [DATA_W-1:0] mem [2][FRAME_LEN];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    wstate_t           state;

    // write-side next-state and control signals
    wstate_t           state_nxt;
    logic [IDX_W-1:0]  wr_idx_nxt;
    logic [IDX_W-1:0]  wr_addr;
    logic              wr_en;
    logic              fill_done;
    logic              discard;

    logic              wr_beat;
    logic              rd_beat;
    logic              rd_done;

    // Gating with reset keeps in_rdy low for the whole time reset is held.
    assign in_rdy   = reset & ~full[wr_bank];
    assign out_vld  = full[rd_bank];
    assign out_data = out_vld ? mem[rd_bank][rd_idx] : '0;
    assign out_fst  = out_vld && (rd_idx == '0);

    assign wr_beat  = in_vld && in_rdy;
    assign rd_beat  = out_vld && out_rdy;
    assign rd_done  = rd_beat && (rd_idx == LAST);

    // Write FSM next state: start on fst, restart on a premature fst, drop stray elements.
    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        wr_addr    = wr_idx;
        wr_en      = 1'b0;
        fill_done  = 1'b0;
        discard    = 1'b0;
        case (state)
            W_IDLE: begin
                if (wr_beat) begin
                    if (in_fst) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        wr_idx_nxt = IDX_W'(1);
                        state_nxt  = W_FILL;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (wr_beat) begin
                    wr_en = 1'b1;
                    if (in_fst) begin
                        // Short frame: the partial is abandoned and this element starts a new one.
                        discard    = 1'b1;
                        wr_addr    = '0;
                        wr_idx_nxt = IDX_W'(1);
                    end else if (wr_idx == LAST) begin
                        fill_done  = 1'b1;
                        wr_idx_nxt = '0;
                        state_nxt  = W_IDLE;
                    end else begin
                        wr_idx_nxt = wr_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = W_IDLE;
                wr_idx_nxt = '0;
            end
        endcase
    end

    // Write FSM state and write-bank pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= W_IDLE;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_idx <= wr_idx_nxt;
            if (fill_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Frame storage; contents are only ever observed behind a full flag, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= in_data;
        end
    end

    // Bank-full flags: fill and drain always target different banks, so both may apply on one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 2'b00;
        end else begin
            if (fill_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read pointer: walk the full bank, then hand it back and move to the other one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_beat) begin
            if (rd_idx == LAST) begin
                rd_idx  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Status: discard pulse, saturating error count, wrapping delivered-frame count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            frame_err <= discard;
            if (discard && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (rd_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
